// File: rtl/apb5_req_arbiter.sv
// Two-requester round-robin arbiter driving one APB5 manager port.
// Ports: PCLK/PRESET (async, active-high); req_* command channel per
// requester (slice i = requester i) with combinational one-hot req_ready;
// rsp_* one-cycle response pulse with shared rdata/slverr; P* APB5
// manager signals. Optional PWAKEUP output when APB5_ARB_WAKEUP_EN is
// defined (default build: absent).
module apb5_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]                req_write,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] req_strb,
  input  logic [5:0]                req_prot,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [2:0]                PPROT,
  input  logic [DATA_WIDTH-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
`ifdef APB5_ARB_WAKEUP_EN
  ,
  output logic                      PWAKEUP
`endif
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic [AW-1:0]   paddr_q;
  logic            pwrite_q;
  logic [DW-1:0]   pwdata_q;
  logic [SW-1:0]   pstrb_q;
  logic [2:0]      pprot_q;
  logic [1:0]      rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_slverr_q;

  logic            done;
  logic            accept;
  logic            win;
  logic [1:0]      cand;
  logic [AW-1:0]   sel_addr;
  logic            sel_write;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_strb;
  logic [2:0]      sel_prot;

  always_comb begin
    done = (state_q == ACCESS) && PREADY;
    // The requester finishing this cycle may not re-win immediately.
    cand = req_valid;
    if (done) cand[grant_q] = 1'b0;
    // grant_q doubles as last_grant for round-robin.
    win = (cand == 2'b11) ? ~grant_q : cand[1];
    req_ready = 2'b00;
    if (!PRESET && (state_q == IDLE || done) && cand != 2'b00)
      req_ready[win] = 1'b1;
    accept = |req_ready;

    sel_addr  = win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    sel_write = win ? req_write[1] : req_write[0];
    sel_wdata = win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    sel_strb  = win ? req_strb[2*SW-1:SW] : req_strb[SW-1:0];
    sel_prot  = win ? req_prot[5:3] : req_prot[2:0];

    state_d = state_q;
    grant_d = accept ? win : grant_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY) state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b1;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (accept) begin
        paddr_q  <= sel_addr;
        pwrite_q <= sel_write;
        pwdata_q <= sel_wdata;
        pstrb_q  <= sel_write ? sel_strb : '0;
        pprot_q  <= sel_prot;
      end
      rsp_valid_q <= 2'b00;
      if (done) begin
        rsp_valid_q[grant_q] <= 1'b1;
        rsp_rdata_q  <= pwrite_q ? '0 : PRDATA;
        rsp_slverr_q <= PSLVERR;
      end
    end
  end

`ifdef APB5_ARB_WAKEUP_EN
  logic wake_q, wake_d;

  always_comb wake_d = (|req_valid) || (state_q != IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wake_q <= 1'b0;
    else        wake_q <= wake_d;
  end

  assign PWAKEUP = wake_q;
`endif

  assign PSEL       = (state_q != IDLE);
  assign PENABLE    = (state_q == ACCESS);
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign PPROT      = pprot_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb5_req_arbiter.sv
// Self-checking bench for apb5_req_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_apb5_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_addr;
  logic [1:0]      req_write;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_strb;
  logic [5:0]      req_prot;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic [2:0]      PPROT;
  logic [DW-1:0]   PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;
`ifdef APB5_ARB_WAKEUP_EN
  logic            PWAKEUP;
`endif

  logic [AW-1:0] c_addr  [2];
  logic          c_write [2];
  logic [DW-1:0] c_wdata [2];
  logic [SW-1:0] c_strb  [2];
  logic [2:0]    c_prot  [2];

  assign req_addr  = {c_addr[1], c_addr[0]};
  assign req_write = {c_write[1], c_write[0]};
  assign req_wdata = {c_wdata[1], c_wdata[0]};
  assign req_strb  = {c_strb[1], c_strb[0]};
  assign req_prot  = {c_prot[1], c_prot[0]};

  int total = 0;
  int bad = 0;

  apb5_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
`ifdef APB5_ARB_WAKEUP_EN
    , .PWAKEUP(PWAKEUP)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic drv();
    @(posedge PCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge PCLK);
  endtask

  task automatic set_cmd(input int i, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] p);
    c_addr[i] = a; c_write[i] = w; c_wdata[i] = d;
    c_strb[i] = s; c_prot[i] = p;
  endtask

  task automatic do_reset();
    PRESET = 1'b1; req_valid = 2'b00;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b11; PREADY = 1'b1;
    smp();
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
         rsp_valid, rsp_rdata, rsp_slverr} !== '0) begin
      bad++;
      $display("FAIL rst_outputs: got psel=%b pen=%b paddr=%h rsp=%b",
               PSEL, PENABLE, PADDR, rsp_valid);
    end
    total++;
    if (req_ready !== 2'b00) begin
      bad++;
      $display("FAIL rst_ready: got %b want 00", req_ready);
    end
`ifdef APB5_ARB_WAKEUP_EN
    total++;
    if (PWAKEUP !== 1'b0) begin
      bad++;
      $display("FAIL rst_wakeup: got %b want 0", PWAKEUP);
    end
`endif
    drv();
    req_valid = 2'b00; PREADY = 1'b0;
    PRESET = 1'b0;
  endtask

  task automatic test_single_write();
    drv();
    set_cmd(0, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010);
    req_valid = 2'b01; PREADY = 1'b1;
    smp();
    total++;
    if (req_ready !== 2'b01 || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL wr_accept: got rdy=%b psel=%b want 01 0",
               req_ready, PSEL);
    end
    drv();
    req_valid = 2'b00;
    smp();
    total++;
    if ({PSEL, PENABLE} !== 2'b10) begin
      bad++;
      $display("FAIL wr_setup: got %b want 10", {PSEL, PENABLE});
    end
    total++;
    if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT} !==
        {32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010}) begin
      bad++;
      $display("FAIL wr_cmd: got a=%h w=%b d=%h s=%h p=%h",
               PADDR, PWRITE, PWDATA, PSTRB, PPROT);
    end
    drv(); smp();
    total++;
    if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL wr_access: got sel/en=%b rsp=%b want 11 00",
               {PSEL, PENABLE}, rsp_valid);
    end
    drv(); smp();
    total++;
    if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 2'b01 ||
        rsp_rdata !== '0 || rsp_slverr !== 1'b0) begin
      bad++;
      $display("FAIL wr_rsp: got sel/en=%b rsp=%b rd=%h err=%b",
               {PSEL, PENABLE}, rsp_valid, rsp_rdata, rsp_slverr);
    end
    drv(); smp();
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    drv();
    set_cmd(1, 32'h20, 1'b0, 32'h12345678, 4'hF, 3'b001);
    req_valid = 2'b10; PREADY = 1'b0;
    smp();
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL rd_accept: got %b want 10", req_ready);
    end
    drv();
    req_valid = 2'b00;
    smp();
    total++;
    if ({PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT} !==
        {2'b10, 32'h20, 1'b0, 4'h0, 3'b001}) begin
      bad++;
      $display("FAIL rd_setup: got sel/en=%b a=%h w=%b s=%h p=%h",
               {PSEL, PENABLE}, PADDR, PWRITE, PSTRB, PPROT);
    end
    for (int k = 0; k < 4; k++) begin
      drv();
      if (k == 3) begin
        PREADY = 1'b1; PRDATA = 32'h5A5A5A5A; PSLVERR = 1'b0;
      end else begin
        PRDATA = $urandom; PSLVERR = 1'b1;
      end
      smp();
      total++;
      if ({PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT} !==
          {2'b11, 32'h20, 1'b0, 4'h0, 3'b001} ||
          rsp_valid !== 2'b00) begin
        bad++;
        $display("FAIL rd_wait%0d: got sel/en=%b a=%h s=%h rsp=%b",
                 k, {PSEL, PENABLE}, PADDR, PSTRB, rsp_valid);
      end
    end
    drv();
    PRDATA = '0; PSLVERR = 1'b1; PREADY = 1'b0;
    smp();
    total++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h5A5A5A5A ||
        rsp_slverr !== 1'b0 || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL rd_rsp: got rsp=%b rd=%h err=%b psel=%b",
               rsp_valid, rsp_rdata, rsp_slverr, PSEL);
    end
    PSLVERR = 1'b0;
  endtask

  task automatic test_error();
    drv();
    set_cmd(0, 32'h44, 1'b1, 32'hCAFE0001, 4'h3, 3'b000);
    req_valid = 2'b01; PREADY = 1'b1;
    smp();
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL err_accept: got %b want 01", req_ready);
    end
    drv();
    req_valid = 2'b00;
    smp();
    drv();
    PSLVERR = 1'b1;
    smp();
    drv();
    PSLVERR = 1'b0;
    smp();
    total++;
    if (rsp_valid !== 2'b01 || rsp_slverr !== 1'b1) begin
      bad++;
      $display("FAIL err_rsp: got rsp=%b err=%b want 01 1",
               rsp_valid, rsp_slverr);
    end
  endtask

  task automatic test_contention();
    int n;
    int last_cyc;
    logic [1:0] want;
    n = 0; last_cyc = 0;
    do_reset();
    set_cmd(0, 32'h100, 1'b1, 32'h0000AAAA, 4'hF, 3'b000);
    set_cmd(1, 32'h200, 1'b0, 32'h0, 4'hF, 3'b000);
    req_valid = 2'b11; PREADY = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      smp();
      if (n >= 1 && n < 4) begin
        total++;
        if (PSEL !== 1'b1) begin
          bad++;
          $display("FAIL cont_psel: got %b want 1 at cyc %0d",
                   PSEL, cyc);
        end
      end
      if (req_ready !== 2'b00) begin
        want = (n % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== want) begin
          bad++;
          $display("FAIL cont_grant%0d: got %b want %b",
                   n, req_ready, want);
        end
        if (n >= 1) begin
          total++;
          if (cyc - last_cyc != 2) begin
            bad++;
            $display("FAIL cont_gap%0d: got %0d want 2",
                     n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n++;
      end
      drv();
      if (n >= 4) req_valid = 2'b00;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL cont_count: got %0d want 4", n);
    end
  endtask

  task automatic test_reset_mid();
    logic seen1;
    seen1 = 1'b0;
    drv();
    set_cmd(1, 32'h300, 1'b0, 32'h0, 4'hF, 3'b100);
    req_valid = 2'b10; PREADY = 1'b0;
    smp();
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL rm_accept: got %b want 10", req_ready);
    end
    drv(); req_valid = 2'b00;
    smp(); drv(); smp();
    drv();
    PRESET = 1'b1; req_valid = 2'b11;
    #1;
    total++;
    if ({PSEL, PENABLE} !== 2'b00 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL rm_abort: got sel/en=%b rdy=%b want 00 00",
               {PSEL, PENABLE}, req_ready);
    end
    @(posedge PCLK);
    #1;
    PRESET = 1'b0; PREADY = 1'b1;
    smp();
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rm_first: got %b want 01", req_ready);
    end
    seen1 = seen1 | rsp_valid[1];
    drv();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      smp();
      seen1 = seen1 | rsp_valid[1];
      drv();
    end
    total++;
    if (seen1 !== 1'b0) begin
      bad++;
      $display("FAIL rm_no_rsp: got %b want 0", seen1);
    end
  endtask

  task automatic test_random();
    bit            m_busy, m_req, m_last, m_rsp_pend, m_rsp_req;
    bit            m_wake_prev;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata, m_rsp_data;
    logic [SW-1:0] m_strb;
    logic [2:0]    m_prot;
    logic          m_rsp_err;
    logic [1:0]    acc, msk, elig, exp_rdy, exp_rv;
    bit            drain, compl, w;
    int            wi;
    m_busy = 0; m_req = 0; m_last = 1; m_rsp_pend = 0;
    m_rsp_req = 0; m_wake_prev = 0; m_age = 0; acc = 2'b00;
    m_addr = '0; m_write = 0; m_wdata = '0; m_strb = '0;
    m_prot = '0; m_rsp_data = '0; m_rsp_err = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drain = (cyc >= 570);
      drv();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && !drain && $urandom_range(0, 2) != 0) begin
          set_cmd(i, $urandom, 1'($urandom_range(0, 1)), $urandom,
                  4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
          req_valid[i] = 1'b1;
        end
      end
      PREADY  = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 3) == 0);
      smp();
      exp_rv = m_rsp_pend ? (m_rsp_req ? 2'b10 : 2'b01) : 2'b00;
      total++;
      if (rsp_valid !== exp_rv) begin
        bad++;
        $display("FAIL rnd_rsp_valid@%0d: got %b want %b",
                 cyc, rsp_valid, exp_rv);
      end
      if (m_rsp_pend) begin
        total++;
        if (rsp_rdata !== m_rsp_data || rsp_slverr !== m_rsp_err) begin
          bad++;
          $display("FAIL rnd_rsp_data@%0d: got %h/%b want %h/%b",
                   cyc, rsp_rdata, rsp_slverr, m_rsp_data, m_rsp_err);
        end
      end
      total++;
      if ({PSEL, PENABLE} !== (m_busy ? {1'b1, m_age > 0} : 2'b00)) begin
        bad++;
        $display("FAIL rnd_phase@%0d: got %b busy=%0d age=%0d",
                 cyc, {PSEL, PENABLE}, m_busy, m_age);
      end
      if (m_busy) begin
        total++;
        if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT} !==
            {m_addr, m_write, m_wdata, m_strb, m_prot}) begin
          bad++;
          $display("FAIL rnd_cmd@%0d: got a=%h s=%h want a=%h s=%h",
                   cyc, PADDR, PSTRB, m_addr, m_strb);
        end
      end
`ifdef APB5_ARB_WAKEUP_EN
      total++;
      if (PWAKEUP !== m_wake_prev) begin
        bad++;
        $display("FAIL rnd_wake@%0d: got %b want %b",
                 cyc, PWAKEUP, m_wake_prev);
      end
`endif
      compl = m_busy && m_age > 0 && PREADY;
      msk = compl ? (m_req ? 2'b10 : 2'b01) : 2'b00;
      elig = req_valid & ~msk;
      exp_rdy = 2'b00;
      w = 0;
      if ((!m_busy || compl) && elig != 2'b00) begin
        w = (elig == 2'b11) ? !m_last : elig[1];
        exp_rdy = w ? 2'b10 : 2'b01;
      end
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rnd_ready@%0d: got %b want %b",
                 cyc, req_ready, exp_rdy);
      end
      m_wake_prev = (req_valid != 2'b00) || m_busy;
      m_rsp_pend = compl;
      if (compl) begin
        m_rsp_req  = m_req;
        m_rsp_data = m_write ? '0 : PRDATA;
        m_rsp_err  = PSLVERR;
      end
      acc = exp_rdy;
      if (exp_rdy != 2'b00) begin
        wi = int'(w);
        m_busy = 1; m_age = 0; m_req = w; m_last = w;
        m_addr = c_addr[wi]; m_write = c_write[wi];
        m_wdata = c_wdata[wi]; m_prot = c_prot[wi];
        m_strb = c_write[wi] ? c_strb[wi] : '0;
      end else if (compl) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_age++;
      end
    end
    drv();
    req_valid = 2'b00;
    repeat (3) drv();
  endtask

`ifdef APB5_ARB_WAKEUP_EN
  task automatic test_wakeup();
    logic [4:0] got;
    drv(); smp();
    total++;
    if (PWAKEUP !== 1'b0) begin
      bad++;
      $display("FAIL wk_idle: got %b want 0", PWAKEUP);
    end
    drv();
    set_cmd(0, 32'h50, 1'b1, 32'h1, 4'h1, 3'b000);
    req_valid = 2'b01; PREADY = 1'b1;
    smp();
    got[0] = PWAKEUP;
    drv(); req_valid = 2'b00;
    smp(); got[1] = PWAKEUP;
    drv(); smp(); got[2] = PWAKEUP;
    drv(); smp(); got[3] = PWAKEUP;
    drv(); smp(); got[4] = PWAKEUP;
    total++;
    if (got !== 5'b01110) begin
      bad++;
      $display("FAIL wk_seq: got %b want 01110 (lsb first cycle)", got);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2; i++)
      set_cmd(i, '0, 1'b0, '0, '0, '0);
    test_reset();
    test_single_write();
    test_read_wait();
    test_error();
    test_contention();
    test_reset_mid();
    test_random();
`ifdef APB5_ARB_WAKEUP_EN
    test_wakeup();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
